// File: rtl/load_store_unit.sv
// Memory stage of the rv32i core: runs one req/gnt/rvalid data-memory transaction per accepted
// load/store and drives the register-file write port with formatted load data.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_idx,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        reg_we,
  output logic [4:0]  rd_src,
  output logic [31:0] rd,
  output logic        misaligned,
  output logic        illegal,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  funct3_q, funct3_nxt;
  logic [1:0]  lane_q, lane_nxt;
  logic [4:0]  rd_idx_q, rd_idx_nxt;
  logic        is_load_q, is_load_nxt;

  logic        in_ready_nxt, mem_req_nxt, mem_we_nxt, reg_we_nxt;
  logic        misaligned_nxt, illegal_nxt, bus_err_nxt;
  logic [31:0] mem_addr_nxt, mem_wdata_nxt, rd_nxt;
  logic [3:0]  mem_wstrb_nxt;
  logic [4:0]  rd_src_nxt;

  logic        op_bad, op_mis, timed_out;
  logic [31:0] rdata_shifted, load_result;

  always_comb begin
    op_bad = 1'b0;
    if (is_load && is_store)
      op_bad = 1'b1;
    else if (is_load)
      op_bad = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else
      op_bad = !(funct3 inside {3'b000, 3'b001, 3'b010});
  end

  assign op_mis = ((funct3[1:0] == 2'b01) && addr[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  assign timed_out = (cnt + 16'd1) == TIMEOUT_CNT;

  // Halfword loads are aligned, so shifting by the byte lane also selects the right half.
  assign rdata_shifted = mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_result = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_result = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_result = {24'd0, rdata_shifted[7:0]};
      3'b101:  load_result = {16'd0, rdata_shifted[15:0]};
      default: load_result = mem_rdata;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + 16'd1;
    funct3_nxt     = funct3_q;
    lane_nxt       = lane_q;
    rd_idx_nxt     = rd_idx_q;
    is_load_nxt    = is_load_q;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    mem_wstrb_nxt  = mem_wstrb;
    rd_src_nxt     = rd_src;
    rd_nxt         = rd;
    reg_we_nxt     = 1'b0;
    misaligned_nxt = 1'b0;
    illegal_nxt    = 1'b0;
    bus_err_nxt    = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = 16'd0;
        if (in_valid && (is_load || is_store)) begin
          if (op_bad) begin
            illegal_nxt = 1'b1;
          end else if (op_mis) begin
            misaligned_nxt = 1'b1;
          end else begin
            state_nxt    = REQ;
            funct3_nxt   = funct3;
            lane_nxt     = addr[1:0];
            rd_idx_nxt   = rd_idx;
            is_load_nxt  = is_load;
            mem_we_nxt   = is_store;
            mem_addr_nxt = {addr[31:2], 2'b00};
            if (is_load) begin
              mem_wstrb_nxt = 4'b0000;
              mem_wdata_nxt = 32'd0;
            end else begin
              case (funct3[1:0])
                2'b00: begin
                  mem_wstrb_nxt = 4'b0001 << addr[1:0];
                  mem_wdata_nxt = {4{wdata[7:0]}};
                end
                2'b01: begin
                  mem_wstrb_nxt = addr[1] ? 4'b1100 : 4'b0011;
                  mem_wdata_nxt = {2{wdata[15:0]}};
                end
                default: begin
                  mem_wstrb_nxt = 4'b1111;
                  mem_wdata_nxt = wdata;
                end
              endcase
            end
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_nxt = is_load_q ? WAIT : IDLE;
          cnt_nxt   = 16'd0;
        end else if (timed_out) begin
          state_nxt   = IDLE;
          bus_err_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_nxt = IDLE;
          if (rd_idx_q != 5'd0) begin
            reg_we_nxt = 1'b1;
            rd_src_nxt = rd_idx_q;
            rd_nxt     = load_result;
          end
        end else if (timed_out) begin
          state_nxt   = IDLE;
          bus_err_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    in_ready_nxt = (state_nxt == IDLE);
    mem_req_nxt  = (state_nxt == REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      funct3_q   <= 3'd0;
      lane_q     <= 2'd0;
      rd_idx_q   <= 5'd0;
      is_load_q  <= 1'b0;
      in_ready   <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'd0;
      reg_we     <= 1'b0;
      rd_src     <= 5'd0;
      rd         <= 32'd0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      funct3_q   <= funct3_nxt;
      lane_q     <= lane_nxt;
      rd_idx_q   <= rd_idx_nxt;
      is_load_q  <= is_load_nxt;
      in_ready   <= in_ready_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      mem_wstrb  <= mem_wstrb_nxt;
      reg_we     <= reg_we_nxt;
      rd_src     <= rd_src_nxt;
      rd         <= rd_nxt;
      misaligned <= misaligned_nxt;
      illegal    <= illegal_nxt;
      bus_err    <= bus_err_nxt;
    end
  end

endmodule
